fsm_egress_drain: RTL

// - Memory-side end of the WB request/response FIFO pair: pops request entries from the egress FIFO,

---
 rtl/fsm_egress_drain_pkg.sv | 34 +++
 rtl/fsm_egress_drain_len_dec.sv | 30 +++
 rtl/fsm_egress_drain.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fsm_egress_drain_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fsm_egress_drain_pkg
//  Purpose  : Shared WB burst encodings, burst lengths and drain FSM states
//  Revision : 1.0 - initial release
// ============================================================================
package fsm_egress_drain_pkg;

    // WB cycle type identifiers that force a single-beat transfer
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // WB burst type extensions
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    // Beat counts handed to the command sequencer
    localparam logic [4:0] LEN_1       = 5'd1;
    localparam logic [4:0] LEN_4       = 5'd4;
    localparam logic [4:0] LEN_8       = 5'd8;
    localparam logic [4:0] LEN_16      = 5'd16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_CMD   = 3'd2,
        ST_WDATA = 3'd3,
        ST_RWAIT = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fsm_egress_drain_len_dec.sv
`default_nettype none
// ============================================================================
//  Module   : fsm_egress_drain_len_dec
//  Purpose  : Burst length decoder (cti, bte -> beats), shared with WB side
//  Revision : 1.0 - initial release
// ============================================================================
module fsm_egress_drain_len_dec
    import fsm_egress_drain_pkg::*;
(
    input  logic [2:0] i_cti,
    input  logic [1:0] i_bte,
    output logic [4:0] o_len
);

    // Classic, end-of-burst and linear cycles move a single beat; wraps set the length
    always_comb begin
        o_len = LEN_1;
        if (i_cti == CTI_CLASSIC || i_cti == CTI_EOB || i_bte == BTE_LINEAR) begin
            o_len = LEN_1;
        end else begin
            case (i_bte)
                BTE_WRAP4: o_len = LEN_4;
                BTE_WRAP8: o_len = LEN_8;
                default:   o_len = LEN_16;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fsm_egress_drain.sv
`default_nettype none
// ============================================================================
//  Module   : fsm_egress_drain
//  Purpose  : Memory-side drain of the WB egress FIFO: one command per
//             transaction, write beats forwarded, read beats pushed to ingress
//  Revision : 1.0 - initial release
// ============================================================================
module fsm_egress_drain
    import fsm_egress_drain_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
)
(
    input  logic              wb_clk,
    input  logic              wb_rst,
    input  logic              i_egress_fifo_empty,
    output logic              o_egress_fifo_re,
    input  logic              i_eg_we,
    input  logic [2:0]        i_eg_cti,
    input  logic [1:0]        i_eg_bte,
    input  logic [AW-1:0]     i_eg_adr,
    input  logic [DW/8-1:0]   i_eg_sel,
    input  logic [DW-1:0]     i_eg_dat,
    output logic              o_cmd_valid,
    input  logic              i_cmd_ready,
    output logic              o_cmd_we,
    output logic [AW-1:0]     o_cmd_adr,
    output logic [4:0]        o_cmd_len,
    output logic              o_wr_valid,
    input  logic              i_wr_ready,
    output logic [DW-1:0]     o_wr_dat,
    output logic [DW/8-1:0]   o_wr_sel,
    output logic              o_wr_last,
    input  logic              i_rd_valid,
    input  logic [DW-1:0]     i_rd_dat,
    output logic              o_ingress_fifo_we,
    output logic [DW-1:0]     o_ingress_fifo_dat,
    input  logic [4:0]        i_ingress_fifo_free,
    output logic              o_busy,
    output logic              o_err
);

    state_t             r_state;
    logic               r_we;
    logic [AW-1:0]      r_adr;
    logic [4:0]         r_len;
    logic               r_cmd_valid;
    logic               r_full;     // beat register holds a write beat
    logic               r_pend;     // popped write beat is on the egress bus now
    logic [DW-1:0]      r_dat;
    logic [DW/8-1:0]    r_sel;
    logic [4:0]         r_cnt;      // beats completed in the current burst
    logic [4:0]         r_pop;      // egress entries consumed by the current burst
    logic               r_err;

    logic [4:0]         w_len;
    logic               w_have;
    logic               w_wr_valid;
    logic               w_wr_acc;
    logic               w_at_last;
    logic               w_more;
    logic               w_re;
    logic               w_rd_push;

    fsm_egress_drain_len_dec u_len_dec (
        .i_cti (i_eg_cti),
        .i_bte (i_eg_bte),
        .o_len (w_len)
    );

    // A beat is presentable either straight off the egress bus or from the
    // holding register, which keeps one beat per cycle without a bubble.
    assign w_have     = r_full | r_pend;
    assign w_wr_valid = (r_state == ST_WDATA) && w_have;
    assign w_wr_acc   = w_wr_valid && i_wr_ready;
    assign w_at_last  = (r_cnt == r_len - 5'd1);
    assign w_more     = (r_pop != r_len);
    assign w_re       = ((r_state == ST_IDLE) && !i_egress_fifo_empty) ||
                        ((r_state == ST_WDATA) && w_more && !i_egress_fifo_empty &&
                         (!w_have || w_wr_acc));
    assign w_rd_push  = (r_state == ST_RWAIT) && i_rd_valid;

    assign o_egress_fifo_re   = w_re;
    assign o_cmd_valid        = r_cmd_valid;
    assign o_cmd_we           = r_we;
    assign o_cmd_adr          = r_adr;
    assign o_cmd_len          = r_len;
    assign o_wr_valid         = w_wr_valid;
    assign o_wr_dat           = r_pend ? i_eg_dat : r_dat;
    assign o_wr_sel           = r_pend ? i_eg_sel : r_sel;
    assign o_wr_last          = w_wr_valid && w_at_last;
    assign o_ingress_fifo_we  = w_rd_push;
    assign o_ingress_fifo_dat = w_rd_push ? i_rd_dat : '0;
    assign o_busy             = (r_state != ST_IDLE);
    assign o_err              = r_err;

    // Drain state machine with its command, beat and error registers
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_len       <= '0;
            r_cmd_valid <= 1'b0;
            r_full      <= 1'b0;
            r_pend      <= 1'b0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_pop       <= '0;
            r_err       <= 1'b0;
        end else begin
            // Read data with no burst to receive it is dropped and flagged
            if (i_rd_valid && r_state != ST_RWAIT) begin
                r_err <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_cnt  <= '0;
                    r_pop  <= '0;
                    r_full <= 1'b0;
                    r_pend <= 1'b0;
                    if (!i_egress_fifo_empty) begin
                        r_state <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    r_we   <= i_eg_we;
                    r_adr  <= i_eg_adr;
                    r_len  <= w_len;
                    r_dat  <= i_eg_dat;
                    r_sel  <= i_eg_sel;
                    r_full <= i_eg_we;
                    r_pop  <= 5'd1;
                    // Reads wait until the ingress FIFO can absorb the whole burst
                    r_cmd_valid <= i_eg_we || (i_ingress_fifo_free >= w_len);
                    r_state     <= ST_CMD;
                end

                ST_CMD: begin
                    if (r_cmd_valid && i_cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= r_we ? ST_WDATA : ST_RWAIT;
                    end else if (r_we || (i_ingress_fifo_free >= r_len)) begin
                        r_cmd_valid <= 1'b1;
                    end
                end

                ST_WDATA: begin
                    if (w_wr_acc) begin
                        r_cnt  <= r_cnt + 5'd1;
                        r_full <= 1'b0;
                    end else if (r_pend) begin
                        // Stalled beat must be captured: the bus is valid for one cycle only
                        r_full <= 1'b1;
                        r_dat  <= i_eg_dat;
                        r_sel  <= i_eg_sel;
                    end
                    r_pend <= w_re;
                    if (w_re) begin
                        r_pop <= r_pop + 5'd1;
                    end
                    if (w_wr_acc && w_at_last) begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_RWAIT: begin
                    if (w_rd_push) begin
                        r_cnt <= r_cnt + 5'd1;
                        if (w_at_last) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
